// File: rtl/adc_scan_pkg.sv
// Shared FSM state encoding and default parameter values for the ADC scan monitor.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        REQ,
        WAIT,
        GAP
    } scan_state_t;

    localparam int unsigned DEF_NUM_CH          = 2;
    localparam int unsigned DEF_ADC_W           = 14;
    localparam int unsigned DEF_AVG_LOG2        = 8;
    localparam int unsigned DEF_INTERVAL_CYCLES = 41946;
    localparam int unsigned DEF_SETTLE_CYCLES   = 1000;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 4096;
    localparam int unsigned DEF_MIN_VALID       = 850;
    localparam int unsigned DEF_HYST            = 16;

endpackage

// File: rtl/adc_avg_channel.sv
// Per-channel block averager with a hysteretic low-level flag.
module adc_avg_channel
    import adc_scan_pkg::*;
#(
    parameter int unsigned ADC_W    = DEF_ADC_W,
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
    parameter int unsigned HYST     = DEF_HYST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_en,
    input  logic [ADC_W-1:0] sample,
    input  logic [ADC_W-1:0] low_thresh,
    output logic [ADC_W-1:0] avg_value,
    output logic             avg_valid,
    output logic             low_flag
);

    localparam int unsigned SUM_W   = ADC_W + AVG_LOG2;
    localparam int unsigned CNT_W   = AVG_LOG2 + 1;
    localparam int unsigned HI_W    = ADC_W + 1;
    localparam int unsigned ADC_MAX = (1 << ADC_W) - 1;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_next_c;
    logic [CNT_W-1:0] count;
    logic             last_c;
    logic [ADC_W-1:0] new_avg_c;
    logic [HI_W-1:0]  hi_raw_c;
    logic [HI_W-1:0]  thresh_hi_c;
    logic             flag_next_c;

    assign sum_next_c = sum + SUM_W'(sample);
    assign last_c     = sample_en && !clear && (count == CNT_W'((1 << AVG_LOG2) - 1));
    assign new_avg_c  = ADC_W'(sum_next_c >> AVG_LOG2);

    // Release threshold saturates at full scale so the flag can always clear.
    assign hi_raw_c    = {1'b0, low_thresh} + HI_W'(HYST);
    assign thresh_hi_c = (hi_raw_c > HI_W'(ADC_MAX)) ? HI_W'(ADC_MAX) : hi_raw_c;

    always_comb begin
        flag_next_c = low_flag;
        if (new_avg_c < low_thresh) begin
            flag_next_c = 1'b1;
        end else if ({1'b0, new_avg_c} >= thresh_hi_c) begin
            flag_next_c = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            count     <= '0;
            avg_value <= '0;
            avg_valid <= 1'b0;
            low_flag  <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                sum   <= '0;
                count <= '0;
            end else if (last_c) begin
                sum       <= '0;
                count     <= '0;
                avg_value <= new_avg_c;
                avg_valid <= 1'b1;
                low_flag  <= flag_next_c;
            end else if (sample_en) begin
                sum   <= sum_next_c;
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_scan_monitor.sv
// Round-robin scanner for a muxed ADC: settle, request, wait, then hold out the slot,
// feeding accepted samples into one averager per channel.
module adc_scan_monitor
    import adc_scan_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned ADC_W           = DEF_ADC_W,
    parameter int unsigned AVG_LOG2        = DEF_AVG_LOG2,
    parameter int unsigned INTERVAL_CYCLES = DEF_INTERVAL_CYCLES,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MIN_VALID       = DEF_MIN_VALID,
    parameter int unsigned HYST            = DEF_HYST
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ena,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic                      clear_avg,
    input  logic [ADC_W-1:0]          low_thresh,
    output logic [$clog2(NUM_CH)-1:0] adc_sel,
    output logic                      adc_req,
    input  logic                      adc_ready,
    input  logic [ADC_W-1:0]          adc_value,
    output logic [NUM_CH*ADC_W-1:0]   avg_value,
    output logic [NUM_CH-1:0]         avg_valid,
    output logic [NUM_CH-1:0]         low_flag,
    output logic                      timeout_err
);

    localparam int unsigned CW     = $clog2(NUM_CH);
    localparam int unsigned SLOT_W = $clog2(INTERVAL_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    scan_state_t       state;
    scan_state_t       next_state;
    logic [CW-1:0]     cur_ch;
    logic [CW-1:0]     next_ch_c;
    logic [SLOT_W-1:0] slot_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              any_mask_c;
    logic              advance_c;
    logic              timeout_c;
    logic              start_c;
    logic              accept_c;

    assign any_mask_c = |ch_mask;
    assign start_c    = (next_state == SETTLE) && (state != SETTLE);
    assign accept_c   = (state == WAIT) && adc_ready &&
                        (adc_value >= ADC_W'(MIN_VALID)) && ch_mask[cur_ch];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        advance_c  = 1'b0;
        timeout_c  = 1'b0;
        case (state)
            IDLE: begin
                if (ena && any_mask_c) begin
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (!ena) begin
                    next_state = IDLE;
                end else if (slot_cnt == SLOT_W'(SETTLE_CYCLES - 1)) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                next_state = ena ? WAIT : IDLE;
            end
            // A started conversion always runs to completion, even with ena low.
            WAIT: begin
                if (adc_ready) begin
                    next_state = GAP;
                end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    next_state = GAP;
                    timeout_c  = 1'b1;
                end
            end
            GAP: begin
                if (slot_cnt == SLOT_W'(INTERVAL_CYCLES - 1)) begin
                    advance_c  = 1'b1;
                    next_state = (ena && any_mask_c) ? SETTLE : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Next enabled channel after the current one; falls back to itself.
    always_comb begin
        int unsigned idx;
        logic        found;
        next_ch_c = cur_ch;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(cur_ch) + k) % NUM_CH;
            if (!found && ch_mask[CW'(idx)]) begin
                next_ch_c = CW'(idx);
                found     = 1'b1;
            end
        end
    end

    // wait_cnt counts cycles since adc_req, so timeout lands TIMEOUT_CYCLES after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_ch      <= '0;
            slot_cnt    <= '0;
            wait_cnt    <= '0;
            adc_sel     <= '0;
            adc_req     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (start_c) begin
                slot_cnt <= '0;
            end else if (state != IDLE) begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            if (state == REQ) begin
                wait_cnt <= WAIT_W'(1);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (advance_c) begin
                cur_ch <= next_ch_c;
            end
            if (start_c) begin
                adc_sel <= advance_c ? next_ch_c : cur_ch;
            end
            adc_req     <= (next_state == REQ);
            timeout_err <= timeout_c;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        adc_avg_channel #(
            .ADC_W    (ADC_W),
            .AVG_LOG2 (AVG_LOG2),
            .HYST     (HYST)
        ) u_ch (
            .clk        (clk),
            .rst        (reset),
            .clear      (clear_avg),
            .sample_en  (accept_c && (cur_ch == CW'(i))),
            .sample     (adc_value),
            .low_thresh (low_thresh),
            .avg_value  (avg_value[i*ADC_W +: ADC_W]),
            .avg_valid  (avg_valid[i]),
            .low_flag   (low_flag[i])
        );
    end

endmodule

// File: tb/tb_adc_scan_monitor.sv
// Directed bench for adc_scan_monitor: scan order, averaging, rejection, timeout,
// hysteresis, clear_avg, ena drop and reset boundaries.
module tb_adc_scan_monitor;

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 14;

    logic            clk = 1'b0;
    logic            reset;
    logic            ena;
    logic [NCH-1:0]  ch_mask;
    logic            clear_avg;
    logic [AW-1:0]   low_thresh;
    logic [1:0]      adc_sel;
    logic            adc_req;
    logic            adc_ready;
    logic [AW-1:0]   adc_value;
    logic [NCH*AW-1:0] avg_value;
    logic [NCH-1:0]  avg_valid;
    logic [NCH-1:0]  low_flag;
    logic            timeout_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int prev_req = -1;
    int ena_cyc  = 0;

    typedef struct {
        int sel;
        int val;
        int mode;   // 0 normal, 1 no response, 2 clear_avg with ready, 3 drop ena in WAIT
        int vld;
        int avg;
        int flag;
    } slot_t;

    slot_t q[$];

    adc_scan_monitor #(
        .NUM_CH          (NCH),
        .ADC_W           (AW),
        .AVG_LOG2        (2),
        .INTERVAL_CYCLES (64),
        .SETTLE_CYCLES   (8),
        .TIMEOUT_CYCLES  (32),
        .MIN_VALID       (850),
        .HYST            (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .ch_mask     (ch_mask),
        .clear_avg   (clear_avg),
        .low_thresh  (low_thresh),
        .adc_sel     (adc_sel),
        .adc_req     (adc_req),
        .adc_ready   (adc_ready),
        .adc_value   (adc_value),
        .avg_value   (avg_value),
        .avg_valid   (avg_valid),
        .low_flag    (low_flag),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic add(input int sel, input int val, input int mode,
                       input int vld, input int avg, input int flag);
        slot_t s;
        s = '{sel, val, mode, vld, avg, flag};
        q.push_back(s);
    endtask

    task automatic wait_req(output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_req && n < 300);
        check("req_seen", 32'(adc_req), 1);
        t = cyc;
    endtask

    task automatic serve(input slot_t s, input int idx);
        int t;
        int to;
        int pulses;
        logic [AW-1:0] a;
        wait_req(t);
        check($sformatf("s%0d_sel", idx), 32'(adc_sel), 32'(s.sel));
        if (prev_req >= 0)
            check($sformatf("s%0d_spacing", idx), 32'(t - prev_req), 64);
        else
            check($sformatf("s%0d_first_req", idx), 32'(t - ena_cyc), 9);
        prev_req = t;
        if (s.mode == 1) begin
            to = -1;
            pulses = 0;
            while (cyc - t < 40) begin
                @(negedge clk);
                if (timeout_err) begin
                    pulses++;
                    if (to < 0) to = cyc - t;
                end
            end
            check($sformatf("s%0d_timeout_lat", idx), 32'(to), 32);
            check($sformatf("s%0d_timeout_pulses", idx), 32'(pulses), 1);
        end else begin
            if (s.mode == 3) begin
                @(negedge clk);
                ena = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                repeat (3) @(negedge clk);
            end
            adc_ready = 1'b1;
            adc_value = AW'(s.val);
            clear_avg = (s.mode == 2);
            @(negedge clk);
            adc_ready = 1'b0;
            clear_avg = 1'b0;
        end
        check($sformatf("s%0d_vld", idx), 32'(avg_valid), 32'(s.vld));
        if (s.vld != 0) begin
            a = avg_value[s.sel*AW +: AW];
            check($sformatf("s%0d_avg", idx), 32'(a), 32'(s.avg));
            check($sformatf("s%0d_flag", idx), 32'(low_flag[s.sel]), 32'(s.flag));
        end
    endtask

    task automatic run_queue(input int base);
        foreach (q[i]) serve(q[i], base + i);
        q.delete();
    endtask

    initial begin
        int reqs;
        reset      = 1'b1;
        ena        = 1'b0;
        ch_mask    = '0;
        clear_avg  = 1'b0;
        low_thresh = '0;
        adc_ready  = 1'b0;
        adc_value  = '0;
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(adc_sel), 0);
        check("rst_req", 32'(adc_req), 0);
        check("rst_avg", 32'(avg_value != '0), 0);
        check("rst_vld", 32'(avg_valid), 0);
        check("rst_flag", 32'(low_flag), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        reset      = 1'b0;
        ch_mask    = 3'b101;
        low_thresh = AW'(1400);
        @(negedge clk);
        ena     = 1'b1;
        ena_cyc = cyc;

        // Scan 0/2, ch0 averaging then rejection+timeout, ch2 hysteresis 1390/1410/1416.
        add(0, 1000, 0, 0, 0, 0);   add(2, 1388, 0, 0, 0, 0);
        add(0, 1004, 0, 0, 0, 0);   add(2, 1390, 0, 0, 0, 0);
        add(0, 1008, 0, 0, 0, 0);   add(2, 1392, 0, 0, 0, 0);
        add(0, 1012, 0, 1, 1006, 1); add(2, 1390, 0, 4, 1390, 1);
        add(0, 849,  0, 0, 0, 0);   add(2, 1410, 0, 0, 0, 0);
        add(0, 0,    1, 0, 0, 0);   add(2, 1410, 0, 0, 0, 0);
        add(0, 900,  0, 0, 0, 0);   add(2, 1410, 0, 0, 0, 0);
        add(0, 900,  0, 0, 0, 0);   add(2, 1410, 0, 4, 1410, 1);
        add(0, 900,  0, 0, 0, 0);   add(2, 1416, 0, 0, 0, 0);
        add(0, 900,  0, 1, 900, 1); add(2, 1416, 0, 0, 0, 0);
        add(0, 1000, 0, 0, 0, 0);   add(2, 1416, 0, 0, 0, 0);
        add(0, 1000, 0, 0, 0, 0);   add(2, 1416, 0, 4, 1416, 0);
        run_queue(0);

        clear_avg = 1'b1;
        ch_mask   = 3'b001;
        @(negedge clk);
        clear_avg = 1'b0;
        check("clr_keeps_avg0", 32'(avg_value[0 +: AW]), 900);
        check("clr_keeps_flags", 32'(low_flag), 1);

        // clear_avg on the 3rd ready discards it; then ena dropped mid-WAIT.
        add(0, 2000, 0, 0, 0, 0);   add(0, 2000, 0, 0, 0, 0);
        add(0, 2000, 2, 0, 0, 0);   add(0, 2100, 0, 0, 0, 0);
        add(0, 2100, 0, 0, 0, 0);   add(0, 2100, 0, 0, 0, 0);
        add(0, 2100, 0, 1, 2100, 0);
        add(0, 3000, 0, 0, 0, 0);   add(0, 3000, 0, 0, 0, 0);
        add(0, 3000, 0, 0, 0, 0);   add(0, 3000, 3, 1, 3000, 0);
        run_queue(100);

        reqs = 0;
        repeat (150) begin
            @(negedge clk);
            if (adc_req) reqs++;
        end
        check("idle_no_req", 32'(reqs), 0);
        check("idle_sel_hold", 32'(adc_sel), 0);

        // Reset in WAIT clears outputs immediately; a late ready is ignored.
        ena      = 1'b1;
        ena_cyc  = cyc;
        prev_req = -1;
        begin
            int t;
            wait_req(t);
            check("rw_first_req", 32'(t - ena_cyc), 9);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ena   = 1'b0;
        #1;
        check("rw_sel", 32'(adc_sel), 0);
        check("rw_req", 32'(adc_req), 0);
        check("rw_avg", 32'(avg_value != '0), 0);
        check("rw_vld", 32'(avg_valid), 0);
        check("rw_flag", 32'(low_flag), 0);
        check("rw_timeout", 32'(timeout_err), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        adc_ready = 1'b1;
        adc_value = AW'(1200);
        @(negedge clk);
        adc_ready = 1'b0;
        check("late_ready_vld", 32'(avg_valid), 0);
        ena      = 1'b1;
        ena_cyc  = cyc;
        prev_req = -1;
        add(0, 1200, 0, 0, 0, 0);   add(0, 1200, 0, 0, 0, 0);
        add(0, 1200, 0, 0, 0, 0);   add(0, 1200, 0, 1, 1200, 1);
        run_queue(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
